// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, state encoding and instruction field layout for proc_ctrl
package proc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int PC_W_DEF   = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_MOVI = 4'h9;
  localparam logic [3:0] OP_BNZ  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 9;
  localparam int RB_HI   = 8;
  localparam int RB_LO   = 6;
  localparam int IMM6_HI = 5;
  localparam int IMM8_HI = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_e;

  // Opcodes that need register operands; everything else retires straight from DECODE.
  function automatic logic needs_operands(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_BNZ);
  endfunction

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational ALU producing the writeback value for one instruction
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [5:0]        imm6_i,
  input  logic [7:0]        imm8_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = a_i;
    case (opcode_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      // Shift amount is only the low nibble of rb, so large rb values alias.
      OP_SHL:  result_o = a_i << b_i[3:0];
      OP_SHR:  result_o = a_i >> b_i[3:0];
      OP_ADDI: result_o = a_i + {{(DATA_W-6){imm6_i[5]}}, imm6_i};
      OP_MOVI: result_o = {{(DATA_W-8){1'b0}}, imm8_i};
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - multi-cycle fetch/decode/read/execute/writeback controller driving an 8-entry register file
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] rf_address_a,
  output logic [ADDR_W-1:0] rf_address_b,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [3:0]          op_q;
  logic [7:0]          imm8_q;
  logic [ADDR_W-1:0]   addr_a_q;
  logic [ADDR_W-1:0]   addr_b_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [3:0]          dec_op_d;
  logic [PC_W-1:0]     pc_inc_d;
  logic [PC_W-1:0]     br_target_d;
  logic [DATA_W-1:0]   alu_result_d;

  assign dec_op_d    = instr_data[OPC_HI:OPC_LO];
  assign pc_inc_d    = pc_q + PC_W'(1);
  assign br_target_d = pc_inc_d + {{(PC_W-6){imm8_q[IMM6_HI]}}, imm8_q[IMM6_HI:0]};

  proc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .opcode_i (op_q),
    .a_i      (rf_data_a),
    .b_i      (rf_data_b),
    .imm6_i   (imm8_q[IMM6_HI:0]),
    .imm8_i   (imm8_q),
    .result_o (alu_result_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      op_q     <= OP_NOP;
      imm8_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      // The write strobe is only ever raised on the EXEC->WB edge, so it lasts one cycle.
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          op_q     <= dec_op_d;
          imm8_q   <= instr_data[IMM8_HI:0];
          addr_a_q <= ADDR_W'(instr_data[RA_HI:RA_LO]);
          addr_b_q <= ADDR_W'(instr_data[RB_HI:RB_LO]);
          if (dec_op_d == OP_HALT) begin
            state_q <= S_HALTED;
          end else if (needs_operands(dec_op_d)) begin
            state_q <= S_READ;
          end else begin
            pc_q    <= pc_inc_d;
            state_q <= S_FETCH;
          end
        end
        S_READ: state_q <= S_EXEC;
        S_EXEC: begin
          if (op_q == OP_BNZ) begin
            pc_q    <= (rf_data_a != '0) ? br_target_d : pc_inc_d;
            state_q <= S_FETCH;
          end else begin
            wdata_q <= alu_result_d;
            we_q    <= 1'b1;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          pc_q    <= pc_inc_d;
          state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_addr      = pc_q;
  assign pc              = pc_q;
  assign rf_address_a    = addr_a_q;
  assign rf_address_b    = addr_b_q;
  assign rf_write_enable = we_q;
  assign rf_write_data   = wdata_q;
  assign busy            = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_READ) ||
                           (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted          = (state_q == S_HALTED);

endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - self-checking bench for proc_ctrl with ROM/register-file models and an instruction-level reference
module tb_proc_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int PC_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PC_W-1:0]   instr_addr;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] rf_address_a;
  logic [ADDR_W-1:0] rf_address_b;
  logic              rf_write_enable;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic              busy;
  logic              halted;
  logic [PC_W-1:0]   pc;

  proc_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .instr_addr      (instr_addr),
    .instr_data      (instr_data),
    .rf_address_a    (rf_address_a),
    .rf_address_b    (rf_address_b),
    .rf_write_enable (rf_write_enable),
    .rf_write_data   (rf_write_data),
    .rf_data_a       (rf_data_a),
    .rf_data_b       (rf_data_b),
    .busy            (busy),
    .halted          (halted),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [15:0] rf [8];
  logic [15:0] exp_rf [8];

  always @(posedge clk) instr_data <= rom[instr_addr];

  always @(posedge clk) begin
    if (rf_write_enable) rf[rf_address_a] <= rf_write_data;
    rf_data_a <= rf[rf_address_a];
    rf_data_b <= rf[rf_address_b];
  end

  int cyc = 0;
  int wr_total = 0;
  int wr_cyc [1024];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rf_write_enable === 1'b1) begin
      wr_cyc[wr_total % 1024] <= cyc;
      wr_total <= wr_total + 1;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [5:0] imm6);
    return {op, ra, rb, imm6};
  endfunction

  function automatic logic [15:0] movi(input logic [2:0] ra, input logic [7:0] imm8);
    return {4'h9, ra, 1'b0, imm8};
  endfunction

  // Start one program and wait for HALTED; lat counts cycles from FETCH of pc 0 to HALTED.
  task automatic run_prog(output int lat, output int c0, output int w0, output bit ok);
    c0 = cyc;
    w0 = wr_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 20000; i++) begin
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    lat = cyc - c0 - 1;
  endtask

  // Instruction-level reference: executes the ROM program on exp_rf.
  task automatic iss(output int lat, output int writes, output int taken, output logic [7:0] fpc);
    logic [7:0]  p;
    logic [15:0] ins;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  i6;
    p = 8'd0; lat = 0; writes = 0; taken = 0; fpc = 8'd0;
    for (int step = 0; step < 5000; step++) begin
      ins = rom[p];
      a   = exp_rf[ins[11:9]];
      b   = exp_rf[ins[8:6]];
      i6  = ins[5:0];
      if (ins[15:12] >= 4'h1 && ins[15:12] <= 4'h9) begin
        case (ins[15:12])
          4'h1: a = a + b;
          4'h2: a = a - b;
          4'h3: a = a & b;
          4'h4: a = a | b;
          4'h5: a = a ^ b;
          4'h6: a = a << b[3:0];
          4'h7: a = a >> b[3:0];
          4'h8: a = a + {{10{i6[5]}}, i6};
          default: a = {8'h00, ins[7:0]};
        endcase
        exp_rf[ins[11:9]] = a;
        writes++;
        lat += 5;
        p = p + 8'd1;
      end else if (ins[15:12] == 4'hA) begin
        lat += 4;
        if (a != 16'd0) begin
          p = p + 8'd1 + {{2{i6[5]}}, i6};
          taken++;
        end else begin
          p = p + 8'd1;
        end
      end else if (ins[15:12] == 4'hF) begin
        lat += 2;
        fpc = p;
        return;
      end else begin
        lat += 2;
        p = p + 8'd1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passes++;
    checks++; if (pc !== 8'd0) $display("FAIL reset_pc got %0d exp 0", pc); else passes++;
    checks++; if (instr_addr !== 8'd0) $display("FAIL reset_instr_addr got %0d exp 0", instr_addr); else passes++;
    checks++; if (rf_write_enable !== 1'b0) $display("FAIL reset_we got %b exp 0", rf_write_enable); else passes++;
    checks++; if (rf_write_data !== 16'd0) $display("FAIL reset_wdata got %h exp 0000", rf_write_data); else passes++;
    checks++; if ({rf_address_a, rf_address_b} !== 6'd0) $display("FAIL reset_addr got %0d/%0d exp 0/0", rf_address_a, rf_address_b); else passes++;
    start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, c0, w0;
    bit ok;
    fill_rom(16'hF000);
    rom[0] = movi(3'd1, 8'd5);
    rom[1] = movi(3'd2, 8'd3);
    rom[2] = enc(4'h1, 3'd1, 3'd2, 6'd0);
    run_prog(lat, c0, w0, ok);
    checks++; if (!ok) $display("FAIL basic_timeout halted never seen"); else passes++;
    checks++; if (rf[1] !== 16'd8) $display("FAIL basic_r1 got %h exp 0008", rf[1]); else passes++;
    checks++; if (rf[2] !== 16'd3) $display("FAIL basic_r2 got %h exp 0003", rf[2]); else passes++;
    checks++; if (halted !== 1'b1) $display("FAIL basic_halted got %b exp 1", halted); else passes++;
    checks++; if (wr_total - w0 !== 3) $display("FAIL basic_writes got %0d exp 3", wr_total - w0); else passes++;
    checks++; if (wr_cyc[w0 % 1024] !== c0 + 5) $display("FAIL basic_first_write got cycle %0d exp %0d", wr_cyc[w0 % 1024] - c0, 5); else passes++;
    checks++; if (lat !== 17) $display("FAIL basic_latency got %0d exp 17", lat); else passes++;
  endtask

  task automatic test_alu_cases();
    int lat, c0, w0;
    bit ok;
    fill_rom(16'hF000);
    rom[0] = movi(3'd1, 8'd3);
    rom[1] = movi(3'd2, 8'd5);
    rom[2] = enc(4'h2, 3'd1, 3'd2, 6'd0);
    rom[3] = movi(3'd3, 8'd1);
    rom[4] = movi(3'd4, 8'h13);
    rom[5] = enc(4'h6, 3'd3, 3'd4, 6'd0);
    rom[6] = movi(3'd0, 8'd0);
    rom[7] = enc(4'h8, 3'd0, 3'd0, 6'h3F);
    rom[8] = movi(3'd5, 8'hFF);
    run_prog(lat, c0, w0, ok);
    checks++; if (!ok) $display("FAIL alu_timeout halted never seen"); else passes++;
    checks++; if (rf[1] !== 16'hFFFE) $display("FAIL alu_sub got %h exp fffe", rf[1]); else passes++;
    checks++; if (rf[3] !== 16'h0008) $display("FAIL alu_shl got %h exp 0008", rf[3]); else passes++;
    checks++; if (rf[0] !== 16'hFFFF) $display("FAIL alu_addi got %h exp ffff", rf[0]); else passes++;
    checks++; if (rf[5] !== 16'h00FF) $display("FAIL alu_movi got %h exp 00ff", rf[5]); else passes++;
    checks++; if (pc !== 8'd9) $display("FAIL alu_halt_pc got %0d exp 9", pc); else passes++;
  endtask

  task automatic test_countdown();
    int lat, c0, w0;
    bit ok;
    fill_rom(16'hF000);
    rom[0] = movi(3'd1, 8'd3);
    rom[1] = enc(4'h8, 3'd1, 3'd0, 6'h3F);
    rom[2] = enc(4'hA, 3'd1, 3'd0, 6'h3E);
    run_prog(lat, c0, w0, ok);
    checks++; if (!ok) $display("FAIL loop_timeout halted never seen"); else passes++;
    checks++; if (rf[1] !== 16'd0) $display("FAIL loop_r1 got %h exp 0000", rf[1]); else passes++;
    checks++; if (wr_total - w0 !== 4) $display("FAIL loop_writes got %0d exp 4", wr_total - w0); else passes++;
    checks++; if (lat !== 34) $display("FAIL loop_latency got %0d exp 34", lat); else passes++;
    checks++; if (pc !== 8'd3) $display("FAIL loop_halt_pc got %0d exp 3", pc); else passes++;
  endtask

  task automatic test_bnz_self();
    int w0;
    fill_rom(16'hF000);
    rom[0] = movi(3'd2, 8'd1);
    rom[1] = enc(4'hA, 3'd2, 3'd0, 6'h3F);
    w0 = wr_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    checks++; if (busy !== 1'b1 || halted !== 1'b0) $display("FAIL selfloop_state got busy=%b halted=%b exp 1/0", busy, halted); else passes++;
    checks++; if (pc !== 8'd1) $display("FAIL selfloop_pc got %0d exp 1", pc); else passes++;
    checks++; if (wr_total - w0 !== 1) $display("FAIL selfloop_writes got %0d exp 1", wr_total - w0); else passes++;
    do_reset();
  endtask

  task automatic test_reset_in_wb();
    int lat, c0, w0;
    bit ok;
    fill_rom(16'hF000);
    rom[0] = movi(3'd6, 8'h15);
    run_prog(lat, c0, w0, ok);
    checks++; if (rf[6] !== 16'h0015) $display("FAIL abort_pre_r6 got %h exp 0015", rf[6]); else passes++;
    rom[0] = movi(3'd6, 8'h2A);
    w0 = wr_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rf_write_enable !== 1'b0) $display("FAIL abort_we got %b exp 0", rf_write_enable); else passes++;
    checks++; if (busy !== 1'b0 || halted !== 1'b0) $display("FAIL abort_idle got busy=%b halted=%b exp 0/0", busy, halted); else passes++;
    checks++; if (pc !== 8'd0) $display("FAIL abort_pc got %0d exp 0", pc); else passes++;
    repeat (3) tick();
    checks++; if (wr_total !== w0) $display("FAIL abort_no_write got %0d strobes exp 0", wr_total - w0); else passes++;
    checks++; if (rf[6] !== 16'h0015) $display("FAIL abort_r6 got %h exp 0015", rf[6]); else passes++;
    run_prog(lat, c0, w0, ok);
    checks++; if (!ok || rf[6] !== 16'h002A) $display("FAIL abort_rerun_r6 got %h exp 002a", rf[6]); else passes++;
    checks++; if (lat !== 7) $display("FAIL abort_rerun_latency got %0d exp 7", lat); else passes++;
  endtask

  task automatic test_nop_reserved_busy_start();
    int c0, w0;
    bit ok;
    fill_rom(16'hF000);
    rom[0] = 16'h0000;
    rom[1] = 16'hC000;
    rom[2] = movi(3'd7, 8'h11);
    c0 = cyc;
    w0 = wr_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc !== 8'd0 || busy !== 1'b1) $display("FAIL nop_pc0 got pc=%0d busy=%b exp 0/1", pc, busy); else passes++;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc !== 8'd1) $display("FAIL nop_pc1 got %0d exp 1", pc); else passes++;
    repeat (2) tick();
    checks++; if (pc !== 8'd2) $display("FAIL reserved_pc2 got %0d exp 2", pc); else passes++;
    checks++; if (wr_total !== w0) $display("FAIL nop_no_write got %0d exp 0", wr_total - w0); else passes++;
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!ok || cyc - c0 - 1 !== 11) $display("FAIL nop_latency got %0d exp 11", cyc - c0 - 1); else passes++;
    checks++; if (rf[7] !== 16'h0011 || wr_total - w0 !== 1) $display("FAIL nop_r7 got %h/%0d exp 0011/1", rf[7], wr_total - w0); else passes++;
  endtask

  task automatic test_halt_restart();
    bit ok;
    fill_rom(16'hF000);
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) $display("FAIL restart_reach_halted halted never seen"); else passes++;
    tick();
    checks++; if (halted !== 1'b0 || busy !== 1'b1 || pc !== 8'd0) $display("FAIL restart_immediate got halted=%b busy=%b pc=%0d exp 0/1/0", halted, busy, pc); else passes++;
    start = 1'b0;
    repeat (4) tick();
    checks++; if (halted !== 1'b1) $display("FAIL restart_halt_again got %b exp 1", halted); else passes++;
  endtask

  task automatic test_pc_wrap();
    int w0;
    fill_rom(16'h0000);
    w0 = wr_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (510) tick();
    checks++; if (pc !== 8'd255) $display("FAIL wrap_pc255 got %0d exp 255", pc); else passes++;
    repeat (2) tick();
    checks++; if (pc !== 8'd0 || busy !== 1'b1) $display("FAIL wrap_pc0 got pc=%0d busy=%b exp 0/1", pc, busy); else passes++;
    checks++; if (wr_total !== w0) $display("FAIL wrap_no_write got %0d exp 0", wr_total - w0); else passes++;
    do_reset();
  endtask

  task automatic test_random();
    int lat, c0, w0, e_lat, e_wr, e_taken;
    bit ok;
    logic [7:0]  e_pc;
    logic [3:0]  op;
    logic [15:0] ins;
    for (int n = 0; n < 6; n++) begin
      fill_rom(16'hF000);
      for (int r = 0; r < 8; r++) rom[r] = movi(3'(r), 8'($urandom));
      for (int k = 8; k < 20; k++) begin
        op = 4'($urandom_range(0, 14));
        ins = enc(op, 3'($urandom), 3'($urandom), 6'($urandom));
        if (op == 4'hA) ins[5:0] = 6'($urandom_range(0, 3));
        rom[k] = ins;
      end
      for (int r = 0; r < 8; r++) exp_rf[r] = 16'd0;
      iss(e_lat, e_wr, e_taken, e_pc);
      run_prog(lat, c0, w0, ok);
      checks++; if (!ok) $display("FAIL rand%0d_timeout halted never seen", n); else passes++;
      for (int r = 0; r < 8; r++) begin
        checks++; if (rf[r] !== exp_rf[r]) $display("FAIL rand%0d_r%0d got %h exp %h", n, r, rf[r], exp_rf[r]); else passes++;
      end
      checks++; if (lat !== e_lat) $display("FAIL rand%0d_latency got %0d exp %0d", n, lat, e_lat); else passes++;
      checks++; if (wr_total - w0 !== e_wr) $display("FAIL rand%0d_writes got %0d exp %0d", n, wr_total - w0, e_wr); else passes++;
      checks++; if (pc !== e_pc) $display("FAIL rand%0d_halt_pc got %0d exp %0d", n, pc, e_pc); else passes++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fill_rom(16'hF000);
    test_reset();
    test_basic();
    test_alu_cases();
    test_countdown();
    test_bnz_self();
    test_reset_in_wb();
    test_nop_reserved_busy_start();
    test_halt_restart();
    test_pc_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
